ws2801_chain_driver: RTL
========================

Name: ws2801_chain_driver

Overview:
Frame-level controller for a daisy-chain of WS2801 LED drivers. On `start` it reads NUM_LEDS 24-bit RGB words from an external frame buffer, one-cycle-latency read port. It serialises each word MSB-first (red[7] first, blue[0] last) onto `led_sdi`/`led_cki`, then holds CKI low for the latch gap so every WS2801 latches. It sits between the frame-buffer/pattern logic and the LED chain pins, and owns all chain timing.

Parameters:
NUM_LEDS, 16, number of WS2801 devices in the chain (>=1)
CLK_DIV, 25, clk cycles per CKI half-period (>=2); bit period = 2*CLK_DIV
LATCH_CYCLES, 30000, clk cycles CKI held low after the last bit (must exceed 500 us of clk)
ADDR_W, $clog2(NUM_LEDS), frame-buffer address width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  request to send one frame; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the latch gap completes
rd_en  out  1  frame-buffer read strobe
rd_addr  out  ADDR_W  LED index being fetched, 0 = first device in chain
rd_data  in  24  RGB word {red,green,blue}, valid the cycle after rd_en
led_sdi  out  1  serial data to chain
led_cki  out  1  serial clock to chain

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, led_sdi=0, led_cki=0, state=IDLE, all counters 0.
- Reset mid-frame: same immediate return to these values. No partial-frame recovery. The next frame's latch gap restores chain sync.
- States: IDLE, FETCH, LOAD, BIT_LO, BIT_HI, LATCH.
- IDLE: `start`=1 moves to FETCH; busy rises the next cycle. `start` is ignored in any other state.
- FETCH (1 cycle): rd_en=1, rd_addr=0.
- LOAD (1 cycle): shift register <= rd_data; bit index=0; LED index=0.
- BIT_LO (CLK_DIV cycles): led_cki=0 and led_sdi=shreg[23], stable for the whole phase.
- BIT_HI (CLK_DIV cycles): led_cki=1 and led_sdi unchanged. On the last cycle, shreg shifts left by 1 and bit index increments.
  - If bit index was not 23: next state is BIT_LO.
  - If it was 23 and LED index < NUM_LEDS-1: load shreg from the prefetch register, increment LED index, go to BIT_LO with no gap.
  - Otherwise go to LATCH.
- Prefetch: during bit 23 of LED n (n < NUM_LEDS-1), rd_en=1 with rd_addr=n+1 on the first cycle of BIT_HI. rd_data is captured into the prefetch register the next cycle. Bit timing is therefore uniform across LED boundaries.
- rd_en is high for exactly one cycle per LED; NUM_LEDS strobes per frame.
- LATCH: led_cki=0, led_sdi=0 for LATCH_CYCLES cycles. Then done=1 for one cycle, busy=0 in that same cycle, and the state returns to IDLE.
- A `start` coincident with done is ignored; it is accepted the following cycle.
- Timing from start-accepted edge:
  - first CKI rise at cycle 2+CLK_DIV;
  - total CKI rising edges per frame = 24*NUM_LEDS;
  - done at 2 + 48*NUM_LEDS*CLK_DIV + LATCH_CYCLES cycles.
- CKI never glitches; each phase holds at least CLK_DIV cycles.
- Counters:
  - phase counter width $clog2(CLK_DIV);
  - latch counter width $clog2(LATCH_CYCLES+1);
  - LED index saturates at NUM_LEDS-1 and does not wrap.

Decomposition:
- Package ws2801_pkg holds:
  - rgb_t packed struct {red, green, blue} (8 bits each, 24 total);
  - driver state enum;
  - WS2801_BITS=24 constant;
  - a function computing LATCH_CYCLES from clock frequency and latch time in µs.
- One sub-module, ws2801_bit_timer: phase counter producing a `phase_end` tick every CLK_DIV cycles, cleared on state entry.

Test Plan:
- Single-frame bit stream (NUM_LEDS=2, CLK_DIV=4, LATCH_CYCLES=40; buffer {0xFF0000, 0x0000A5}), pulse start -> required response:
  - exactly 48 CKI rises;
  - SDI sampled on rises = 8×1, 16×0, 16×0, then 10100101;
  - done at cycle 2+384+40=426.
- Read-port protocol, same config -> rd_en pulses exactly twice: addr 0 at cycle 0, addr 1 on the first BIT_HI cycle of LED0 bit 23. No stall between bits 23 and 24; every bit phase is 4 cycles.
- Chain check: two LED models chained (SDO/CKO -> SDI/CKI), 1 MHz model latch, clk 50 MHz, CLK_DIV=25, LATCH_CYCLES=30000; buffer {0x123456, 0xABCDEF} -> after done, model0.rgb=0x123456 and model1.rgb=0xABCDEF.
- Start handling -> start pulses while busy and a start coincident with done are ignored: only one frame is emitted, busy never re-rises early, and a start one cycle after done begins a new frame.
- Mid-frame reset: assert reset_n=0 during LED1 bit 10 -> all outputs are 0 immediately (asynchronous). After release, a new start yields a correct full frame and the chain models hold the new values.

Source files
------------

// File: rtl/ws2801_pkg.sv
// Shared types and constants for the WS2801 chain driver.
//   rgb_t             : one device's colour word, red in the top byte
//   drv_state_e       : driver FSM state encoding
//   WS2801_BITS       : bits shifted per device
//   calc_latch_cycles : clk cycles covering a latch gap given in microseconds
package ws2801_pkg;

    localparam int unsigned WS2801_BITS = 24;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_BIT_LO = 3'd3,
        ST_BIT_HI = 3'd4,
        ST_LATCH  = 3'd5
    } drv_state_e;

    // Rounded up so the gap is never shorter than requested.
    function automatic int unsigned calc_latch_cycles(input int unsigned clk_hz,
                                                      input int unsigned latch_us);
        longint unsigned cyc;
        cyc = (64'(clk_hz) * 64'(latch_us) + 64'd999_999) / 64'd1_000_000;
        return 32'(cyc);
    endfunction

endpackage

// File: rtl/ws2801_bit_timer.sv
// Phase timer for one CKI half-period.
//   clk, rst_n  : clock, async active-low reset
//   clear_i     : restart the phase (asserted on FSM state entry)
//   en_i        : count while a bit phase is active
//   phase_end_o : high during the last cycle of each CLK_DIV-cycle phase
module ws2801_bit_timer
    import ws2801_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic phase_end_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_end_d;

    // Tick is registered from the next count so it lines up with cnt_q == LAST.
    always_comb begin
        cnt_d       = cnt_q;
        phase_end_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            phase_end_d = (cnt_d == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            phase_end_o <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            phase_end_o <= phase_end_d;
        end
    end

endmodule

// File: rtl/ws2801_chain_driver.sv
// Frame controller for a daisy chain of WS2801 devices.
//   clk, reset_n      : clock, async active-low reset
//   start             : send one frame (taken only in IDLE, not on the done cycle)
//   busy, done        : frame in progress / one-cycle completion pulse
//   rd_en, rd_addr    : frame-buffer read strobe and LED index
//   rd_data           : RGB word, valid the cycle after rd_en
//   led_sdi, led_cki  : serial data and clock to the chain
module ws2801_chain_driver
    import ws2801_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = 16,
    parameter int unsigned CLK_DIV      = 25,
    parameter int unsigned LATCH_CYCLES = 30000,
    parameter int unsigned ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [WS2801_BITS-1:0]       rd_data,
    output logic                         led_sdi,
    output logic                         led_cki
);

    localparam int unsigned LAT_W = $clog2(LATCH_CYCLES + 1);
    localparam int unsigned BIT_W = 5;

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_FETCH  = 3'(ST_FETCH);
    localparam logic [2:0] S_LOAD   = 3'(ST_LOAD);
    localparam logic [2:0] S_BIT_LO = 3'(ST_BIT_LO);
    localparam logic [2:0] S_BIT_HI = 3'(ST_BIT_HI);
    localparam logic [2:0] S_LATCH  = 3'(ST_LATCH);

    localparam logic [ADDR_W-1:0] LAST_LED = ADDR_W'(NUM_LEDS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WS2801_BITS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    logic [2:0]              state_q, state_d;
    logic [WS2801_BITS-1:0]  shreg_q, shreg_d;
    rgb_t                    pref_q, pref_d;
    logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
    logic [ADDR_W-1:0]       led_idx_q, led_idx_d;
    logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    busy_d, done_d, rd_en_d, led_sdi_d, led_cki_d;
    logic [ADDR_W-1:0]       rd_addr_d;
    logic                    phase_end;
    logic                    in_bit;

    assign in_bit = (state_q == S_BIT_LO) || (state_q == S_BIT_HI);

    ws2801_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk         (clk),
        .rst_n       (reset_n),
        .clear_i     (state_d != state_q),
        .en_i        (in_bit),
        .phase_end_o (phase_end)
    );

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        pref_d     = pref_q;
        bit_idx_d  = bit_idx_q;
        led_idx_d  = led_idx_q;
        lat_cnt_d  = '0;
        rd_valid_d = rd_en;
        busy_d     = busy;
        done_d     = 1'b0;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr;

        // Prefetched word arrives one cycle after its strobe.
        if (rd_valid_q) begin
            pref_d = rgb_t'(rd_data);
        end

        case (state_q)
            S_IDLE: begin
                if (start && !done) begin
                    state_d   = S_FETCH;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shreg_d   = rd_data;
                bit_idx_d = '0;
                led_idx_d = '0;
                state_d   = S_BIT_LO;
            end
            S_BIT_LO: begin
                if (phase_end) begin
                    state_d = S_BIT_HI;
                    // Fetch the next device's word on the first high cycle of bit 23.
                    if (bit_idx_q == LAST_BIT && led_idx_q < LAST_LED) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = led_idx_q + ADDR_W'(1);
                    end
                end
            end
            S_BIT_HI: begin
                if (phase_end) begin
                    shreg_d = {shreg_q[WS2801_BITS-2:0], 1'b0};
                    if (bit_idx_q != LAST_BIT) begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        state_d   = S_BIT_LO;
                    end else if (led_idx_q < LAST_LED) begin
                        // With CLK_DIV=2 the word is still on rd_data this cycle.
                        shreg_d   = rd_valid_q ? rd_data : pref_q;
                        bit_idx_d = '0;
                        led_idx_d = led_idx_q + ADDR_W'(1);
                        state_d   = S_BIT_LO;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q == LAT_LAST) begin
                    lat_cnt_d = '0;
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        led_cki_d = (state_d == S_BIT_HI);
        led_sdi_d = ((state_d == S_BIT_LO) || (state_d == S_BIT_HI)) ?
                    shreg_d[WS2801_BITS-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            pref_q     <= '0;
            bit_idx_q  <= '0;
            led_idx_q  <= '0;
            lat_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            led_sdi    <= 1'b0;
            led_cki    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            pref_q     <= pref_d;
            bit_idx_q  <= bit_idx_d;
            led_idx_q  <= led_idx_d;
            lat_cnt_q  <= lat_cnt_d;
            rd_valid_q <= rd_valid_d;
            busy       <= busy_d;
            done       <= done_d;
            rd_en      <= rd_en_d;
            rd_addr    <= rd_addr_d;
            led_sdi    <= led_sdi_d;
            led_cki    <= led_cki_d;
        end
    end

endmodule
